// File: rtl/decode_stage_onehot.sv
// Registered decode stage: one instruction per cycle over valid/ready, decoded
// into an 18-bit one-hot control vector plus an illegal flag. Mul/div entries
// stay invisible for MD_LAT cycles to model multicycle-unit occupancy.
module decode_stage_onehot #(
  parameter int INSN_W = 32,
  parameter int MD_LAT = 32,
  parameter bit MD_EN  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INSN_W-1:0] in_insn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSN_W-1:0] out_insn,
  output logic [17:0]       out_ctrl,
  output logic              out_illegal,
  output logic              md_busy
);

  localparam int CW = $clog2(MD_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(MD_LAT);

  logic              out_valid_q;
  logic [INSN_W-1:0] out_insn_q;
  logic [17:0]       out_ctrl_q;
  logic              out_illegal_q;
  logic [CW-1:0]     cnt_q;

  logic [4:0]  opc, alu;
  logic [17:0] ctrl_d;
  logic        ill_d;
  logic        is_md_d;
  logic        accept;

  assign opc = in_insn[31:27];
  assign alu = in_insn[6:2];

  // Busy is simply "countdown not yet finished"; derived from the counter
  // register so it can never disagree with it.
  assign md_busy  = (cnt_q != '0);
  assign in_ready = !md_busy && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  assign out_valid   = out_valid_q;
  assign out_insn    = out_insn_q;
  assign out_ctrl    = out_ctrl_q;
  assign out_illegal = out_illegal_q;

  // Opcode / ALU-op decode into one-hot control; anything undefined is illegal.
  always_comb begin
    ctrl_d  = '0;
    ill_d   = 1'b0;
    is_md_d = 1'b0;
    unique case (opc)
      5'b00000: begin
        unique case (alu)
          5'b00000: ctrl_d[0] = 1'b1;
          5'b00001: ctrl_d[2] = 1'b1;
          5'b00010: ctrl_d[3] = 1'b1;
          5'b00011: ctrl_d[4] = 1'b1;
          5'b00100: ctrl_d[5] = 1'b1;
          5'b00101: ctrl_d[6] = 1'b1;
          5'b00110: begin
            if (MD_EN) begin
              ctrl_d[16] = 1'b1;
              is_md_d    = 1'b1;
            end else begin
              ill_d = 1'b1;
            end
          end
          5'b00111: begin
            if (MD_EN) begin
              ctrl_d[17] = 1'b1;
              is_md_d    = 1'b1;
            end else begin
              ill_d = 1'b1;
            end
          end
          default: ill_d = 1'b1;
        endcase
      end
      5'b00101: ctrl_d[1]  = 1'b1;
      5'b00111: ctrl_d[7]  = 1'b1;
      5'b01000: ctrl_d[8]  = 1'b1;
      5'b00001: ctrl_d[9]  = 1'b1;
      5'b00010: ctrl_d[10] = 1'b1;
      5'b00011: ctrl_d[11] = 1'b1;
      5'b00100: ctrl_d[12] = 1'b1;
      5'b00110: ctrl_d[13] = 1'b1;
      5'b10110: ctrl_d[14] = 1'b1;
      5'b10101: ctrl_d[15] = 1'b1;
      default:  ill_d      = 1'b1;
    endcase
  end

  // Output register and mul/div countdown; flush outranks accept and consume.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_insn_q    <= '0;
      out_ctrl_q    <= '0;
      out_illegal_q <= 1'b0;
      cnt_q         <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else if (accept) begin
      out_insn_q    <= in_insn;
      out_ctrl_q    <= ctrl_d;
      out_illegal_q <= ill_d;
      if (is_md_d) begin
        cnt_q       <= LAT;
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= 1'b1;
      end
    end else if (cnt_q != '0) begin
      // Entry becomes visible on the same edge the counter reaches zero.
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) out_valid_q <= 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage_onehot.sv
// Directed bench for decode_stage_onehot: a vector table for the decode and
// full-throughput path, plus hand sequences for hold, mul/div countdown,
// flush, reset mid-countdown and the MD_EN=0 variant.
module tb_decode_stage_onehot;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_insn;

  logic        in_ready, out_valid, out_illegal, md_busy;
  logic [31:0] out_insn;
  logic [17:0] out_ctrl;

  logic        in_ready0, out_valid0, out_illegal0, md_busy0;
  logic [31:0] out_insn0;
  logic [17:0] out_ctrl0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  decode_stage_onehot #(.INSN_W(32), .MD_LAT(4), .MD_EN(1'b1)) u_dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .in_insn(in_insn), .out_valid(out_valid),
    .out_ready(out_ready), .out_insn(out_insn), .out_ctrl(out_ctrl),
    .out_illegal(out_illegal), .md_busy(md_busy));

  decode_stage_onehot #(.INSN_W(32), .MD_LAT(4), .MD_EN(1'b0)) u_dut0 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready0), .in_insn(in_insn), .out_valid(out_valid0),
    .out_ready(out_ready), .out_insn(out_insn0), .out_ctrl(out_ctrl0),
    .out_illegal(out_illegal0), .md_busy(md_busy0));

  typedef struct {
    logic [31:0] insn;
    logic [17:0] ctrl;
    logic        ill;
  } vec_t;

  vec_t vecs[20];

  localparam logic [31:0] I_ADD = 32'h0000_0000;
  localparam logic [31:0] I_SUB = 32'h0000_0004;
  localparam logic [31:0] I_SW  = 32'h3800_0000;
  localparam logic [31:0] I_MUL = 32'h0000_0018;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic ordy, input logic fl);
    in_valid  = v;
    in_insn   = insn;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    vecs[0]  = '{I_ADD,        18'h00001, 1'b0};
    vecs[1]  = '{I_SUB,        18'h00004, 1'b0};
    vecs[2]  = '{32'h4000_0000, 18'h00100, 1'b0}; // lw
    vecs[3]  = '{32'hB000_0000, 18'h04000, 1'b0}; // bex
    vecs[4]  = '{32'h0000_0008, 18'h00008, 1'b0}; // and
    vecs[5]  = '{32'h0000_000C, 18'h00010, 1'b0}; // or
    vecs[6]  = '{32'h0000_0010, 18'h00020, 1'b0}; // sll
    vecs[7]  = '{32'h0000_0014, 18'h00040, 1'b0}; // sra
    vecs[8]  = '{32'h2800_003C, 18'h00002, 1'b0}; // addi, ALU field ignored
    vecs[9]  = '{I_SW,         18'h00080, 1'b0};
    vecs[10] = '{32'h0800_0000, 18'h00200, 1'b0}; // j
    vecs[11] = '{32'h1000_0000, 18'h00400, 1'b0}; // bne
    vecs[12] = '{32'h1800_0000, 18'h00800, 1'b0}; // jal
    vecs[13] = '{32'h2000_0000, 18'h01000, 1'b0}; // jr
    vecs[14] = '{32'h3000_0000, 18'h02000, 1'b0}; // blt
    vecs[15] = '{32'hA800_0000, 18'h08000, 1'b0}; // setx
    vecs[16] = '{32'hF800_0000, 18'h00000, 1'b1}; // opcode 11111
    vecs[17] = '{32'h0000_0028, 18'h00000, 1'b1}; // R-type ALU-op 01010
    vecs[18] = '{32'h4800_0000, 18'h00000, 1'b1}; // opcode 01001
    vecs[19] = '{32'h0000_0000, 18'h00001, 1'b0}; // zero word is add

    // 1: reset held 2 cycles while in_valid=1
    reset = 1'b1;
    drive(1'b1, I_SUB, 1'b1, 1'b0);
    step();
    step();
    reset = 1'b0;
    drive(1'b0, I_ADD, 1'b1, 1'b0);
    #1;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_ctrl", {14'd0, out_ctrl}, 32'd0);
    check("rst out_illegal", {31'd0, out_illegal}, 32'd0);
    check("rst out_insn", out_insn, 32'd0);
    check("rst md_busy", {31'd0, md_busy}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);

    // 2/6: back-to-back decode table at full throughput
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, vecs[i].insn, 1'b1, 1'b0);
      #1;
      check($sformatf("tbl%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      step();
      check($sformatf("tbl%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("tbl%0d out_ctrl", i), {14'd0, out_ctrl}, {14'd0, vecs[i].ctrl});
      check($sformatf("tbl%0d out_illegal", i), {31'd0, out_illegal}, {31'd0, vecs[i].ill});
      check($sformatf("tbl%0d out_insn", i), out_insn, vecs[i].insn);
      check($sformatf("tbl%0d onehot", i), $countones({out_ctrl, out_illegal}), 32'd1);
    end
    drive(1'b0, I_ADD, 1'b1, 1'b0);
    step();
    check("drain out_valid", {31'd0, out_valid}, 32'd0);

    // 3: sw held stable while execute stalls
    drive(1'b1, I_SW, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, I_ADD, 1'b0, 1'b0);
      #1;
      check($sformatf("hold%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      step();
      check($sformatf("hold%0d out_valid", k), {31'd0, out_valid}, 32'd1);
      check($sformatf("hold%0d out_ctrl", k), {14'd0, out_ctrl}, 32'h80);
      check($sformatf("hold%0d out_insn", k), out_insn, I_SW);
    end
    drive(1'b0, I_ADD, 1'b1, 1'b0);
    #1;
    check("hold release in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("hold consumed", {31'd0, out_valid}, 32'd0);

    // 4: mul countdown, MD_LAT=4
    drive(1'b1, I_MUL, 1'b1, 1'b0);
    step();
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("mul t+%0d md_busy", k), {31'd0, md_busy}, 32'd1);
      check($sformatf("mul t+%0d out_valid", k), {31'd0, out_valid}, 32'd0);
      drive(k < 4, I_ADD, 1'b1, 1'b0);
      #1;
      check($sformatf("mul t+%0d in_ready", k), {31'd0, in_ready}, 32'd0);
      step();
    end
    check("mul t+5 out_valid", {31'd0, out_valid}, 32'd1);
    check("mul t+5 md_busy", {31'd0, md_busy}, 32'd0);
    check("mul t+5 out_ctrl", {14'd0, out_ctrl}, 32'h10000);
    check("mul t+5 out_insn", out_insn, I_MUL);
    drive(1'b0, I_ADD, 1'b1, 1'b0);
    step();
    check("mul consumed", {31'd0, out_valid}, 32'd0);

    // 5: flush at t+2 of a mul countdown, with in_valid=1
    drive(1'b1, I_MUL, 1'b1, 1'b0);
    step();
    drive(1'b0, I_ADD, 1'b1, 1'b0);
    step();
    drive(1'b1, I_SUB, 1'b1, 1'b1);
    step();
    drive(1'b0, I_ADD, 1'b1, 1'b0);
    #1;
    check("flush md_busy", {31'd0, md_busy}, 32'd0);
    check("flush out_valid", {31'd0, out_valid}, 32'd0);
    check("flush in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("flush quiet%0d", k), {31'd0, out_valid | md_busy}, 32'd0);
    end

    // flush drops an insn even when in_ready=1
    drive(1'b1, I_SUB, 1'b1, 1'b1);
    #1;
    check("flushacc in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("flushacc out_valid", {31'd0, out_valid}, 32'd0);

    // flush beats a stalled valid entry
    drive(1'b1, I_ADD, 1'b0, 1'b0);
    step();
    drive(1'b0, I_ADD, 1'b0, 1'b1);
    step();
    check("flushheld out_valid", {31'd0, out_valid}, 32'd0);

    // reset mid-countdown leaves no residual busy
    drive(1'b1, I_MUL, 1'b1, 1'b0);
    step();
    drive(1'b0, I_ADD, 1'b1, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstmid md_busy", {31'd0, md_busy}, 32'd0);
    for (int k = 0; k < 5; k++) step();
    check("rstmid out_valid", {31'd0, out_valid}, 32'd0);

    // 6: mul with MD_EN=0 is illegal and immediately visible
    drive(1'b1, I_MUL, 1'b1, 1'b0);
    step();
    check("md_en0 out_valid", {31'd0, out_valid0}, 32'd1);
    check("md_en0 out_illegal", {31'd0, out_illegal0}, 32'd1);
    check("md_en0 out_ctrl", {14'd0, out_ctrl0}, 32'd0);
    check("md_en0 md_busy", {31'd0, md_busy0}, 32'd0);
    check("md_en0 onehot", $countones({out_ctrl0, out_illegal0}), 32'd1);
    drive(1'b1, 32'h0000_001C, 1'b1, 1'b0); // div
    step();
    check("md_en0 div illegal", {31'd0, out_illegal0}, 32'd1);
    drive(1'b0, I_ADD, 1'b1, 1'b1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach end");
    $fatal(1);
  end

endmodule
